pe_stream_mac: RTL and testbench
================================

// Module: pe_stream_mac
// PURPOSE
//  Sequential, parametrised successor to the combinational sign-magnitude PE: computes
//  sat(bias + sum_i in[i]*w[i]) over N_IN sign-magnitude operands, streamed LANES pairs/beat.
//  Lives in the neural-processor datapath, fed by the activation/weight buffers; one result per job.
//  Adds valid/ready handshakes, multi-beat accumulation, optional ReLU and output right-shift.
// PARAMETERS
//  DATA_W    8   operand/bias/output width; MSB = sign, DATA_W-1 bits magnitude
//  N_IN      62  operand pairs per job
//  LANES     4   pairs consumed per accepted beat; NBEATS = ceil(N_IN/LANES)
//  ACC_W     24  two's-complement accumulator width; >= 2*(DATA_W-1)+clog2(N_IN+1)+2
//  OUT_SHIFT 0   right shift applied to |acc| before saturation (truncates toward zero)
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              asynchronous, active-high reset
//  start      in   1              job request; sampled only in IDLE
//  bias       in   DATA_W         sign-magnitude bias, captured when start accepted
//  relu_en    in   1              captured with start; 1 = clamp negative results to 0
//  busy       out  1              high in every state except IDLE
//  in_valid   in   1              operand beat valid
//  in_ready   out  1              high only in ACCUM
//  in_data    in   LANES*DATA_W   activations, lane k at bits [k*DATA_W +: DATA_W]
//  w_data     in   LANES*DATA_W   weights, same lane packing
//  out_valid  out  1              result valid; held until accepted
//  out_ready  in   1              downstream accept
//  out        out  DATA_W         sign-magnitude result
// BEHAVIOUR
//  Reset (async): state=IDLE; busy, in_ready, out_valid = 0; out = 0; acc, beat count = 0.
//  FSM IDLE->ACCUM->SAT->OUT->IDLE.
//   IDLE: start=1 -> acc <= sign-extended tc(bias), latch relu_en, cnt <= 0, go ACCUM.
//   ACCUM: beat accepted when in_valid&in_ready; acc += sum of valid lane products;
//    cnt++. Accepting beat cnt==NBEATS-1 -> SAT. No beat -> hold (no timeout).
//   SAT: one cycle; out <= format(acc); out_valid <= 1 at its end -> OUT.
//   OUT: hold out/out_valid stable until out_valid&out_ready; then out_valid <= 0, IDLE.
//  Latency: out_valid rises at the 2nd rising edge after the last-beat handshake edge.
//  start outside IDLE is ignored (no queueing); start in the OUT-accept cycle also ignored.
//  Lane masking: lane k of beat b used only if b*LANES+k < N_IN; others ignored (any X/value).
//  Products: |p| = |in|*|w| (2*(DATA_W-1) bits), sign = s_in ^ s_w; -0 treated as 0.
//  Accumulate in ACC_W-bit two's complement; never overflows given ACC_W rule.
//  format(acc): m = |acc| >> OUT_SHIFT; if relu and acc<0 -> 0; else if m > 2^(DATA_W-1)-1
//   -> sign | all-ones magnitude (+max 0x7F / -max 0xFF for DATA_W=8); else sign|m.
//   Zero result is always 0x00 (never negative zero), including negative acc shifted to 0.
//  rst mid-job: job discarded, outputs return to reset values asynchronously.
// STRUCTURE
//  pe_defs.vh (shared include): FSM state encodings, SM_MAG_MAX, functions sm_to_tc(),
//   tc_to_sm_sat(), clog2; reused by future PE variants.
//  Sub-module pe_sm_mult: one-lane sign-magnitude multiplier -> signed product; generated x LANES.
//  Top: lane masking, adder tree into acc, beat counter, FSM, output register.
// TESTING (DATA_W=8, OUT_SHIFT=0 unless noted)
//  1 N_IN=4,LANES=4: in={+100,+93,-103,-127}, w={-5,+4,-3,+2}, bias=+100 -> sum -73+100 -> out 0x1B.
//  2 N_IN=62: all in=+127,w=+127,bias=+100 -> 0x7F; same with w=-127 -> 0xFF; latency checked.
//  3 N_IN=6,LANES=4: 2 beats, beat2 lanes 2-3 random; in=+1,w=+2 real lanes, bias=0 -> 0x0C.
//  4 All in=0, bias=0x80 (-0) -> 0x00; case 1 with OUT_SHIFT=2 -> 27>>2 -> 0x06.
//  5 Case 1 with bias=-100 (0xE4): relu_en=0 -> -173 -> 0xFF; relu_en=1 -> 0x00.
//  6 in_valid gaps + out_ready low 5 cycles: out stable, start ignored while busy; rst in ACCUM
//    -> in_ready/out_valid/busy 0 at once; next job (case 1) -> 0x1B.

Source files
------------

// File: rtl/pe_stream_mac_pkg.sv
// Shared definitions for the streaming sign-magnitude PE family: FSM encoding
// and small elaboration-time helpers reused by future PE variants.
package pe_stream_mac_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_SAT   = 2'd2,
      ST_OUT   = 2'd3
   } pe_state_t;

   function automatic int sm_mag_max(input int data_w);
      return (1 << (data_w - 1)) - 1;
   endfunction

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // Lanes past the last real operand pair of the final beat carry don't-care data.
   function automatic bit lane_active(input int beat, input int lane, input int lanes,
                                      input int n_in);
      return (beat * lanes + lane) < n_in;
   endfunction

endpackage

// File: rtl/pe_stream_mac_sm_mult.sv
// One-lane sign-magnitude multiplier producing a two's-complement product;
// a zero magnitude always yields +0 regardless of operand signs.
module pe_stream_mac_sm_mult #(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0]            a,
   input  logic [DATA_W-1:0]            b,
   output logic signed [2*DATA_W-2:0]   prod
);

   localparam int MAG_W = DATA_W - 1;

   logic [2*MAG_W-1:0] mag;
   logic               neg;

   always_comb begin
      mag  = a[MAG_W-1:0] * b[MAG_W-1:0];
      neg  = (a[DATA_W-1] ^ b[DATA_W-1]) && (mag != '0);
      prod = neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
   end

endmodule

// File: rtl/pe_stream_mac.sv
// Streaming sign-magnitude MAC: sat(bias + sum in[i]*w[i]) over N_IN pairs,
// LANES pairs per beat, with optional ReLU and output right-shift.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; bias/relu captured on start
// ST_ACCUM | accepting operand beats until the last one is taken
// ST_SAT   | one cycle: format accumulator into the output register
// ST_OUT   | result held with out_valid until downstream accepts
module pe_stream_mac
   import pe_stream_mac_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int N_IN      = 62,
   parameter int LANES     = 4,
   parameter int ACC_W     = 24,
   parameter int OUT_SHIFT = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [DATA_W-1:0]         bias,
   input  logic                      relu_en,
   output logic                      busy,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*DATA_W-1:0]   in_data,
   input  logic [LANES*DATA_W-1:0]   w_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out
);

   localparam int MAG_W   = DATA_W - 1;
   localparam int PROD_W  = 2 * MAG_W + 1;
   localparam int NBEATS  = ceil_div(N_IN, LANES);
   localparam int CNT_W   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int MAG_MAX = sm_mag_max(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

   pe_state_t                 state, state_nxt;
   logic [CNT_W-1:0]          cnt;
   logic signed [ACC_W-1:0]   acc;
   logic                      relu_q;
   logic [DATA_W-1:0]         out_q;
   logic                      out_valid_q;

   logic signed [PROD_W-1:0]  prod [LANES];
   logic signed [ACC_W-1:0]   beat_sum;
   logic signed [ACC_W-1:0]   bias_tc;
   logic                      accept;
   logic                      acc_neg;
   logic [ACC_W-1:0]          acc_abs;
   logic [ACC_W-1:0]          acc_shift;
   logic [DATA_W-1:0]         fmt;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      pe_stream_mac_sm_mult #(.DATA_W(DATA_W)) u_mult (
         .a    (in_data[k*DATA_W +: DATA_W]),
         .b    (w_data[k*DATA_W +: DATA_W]),
         .prod (prod[k])
      );
   end

   assign accept = in_valid && (state == ST_ACCUM);

   always_comb begin
      beat_sum = '0;
      for (int k = 0; k < LANES; k++) begin
         if (lane_active(int'(cnt), k, LANES, N_IN))
            beat_sum = beat_sum + ACC_W'(prod[k]);
      end
   end

   always_comb begin
      bias_tc = $signed({{(ACC_W-MAG_W){1'b0}}, bias[MAG_W-1:0]});
      if (bias[DATA_W-1])
         bias_tc = -bias_tc;
   end

   // Shift acts on the magnitude so it truncates toward zero for both signs.
   always_comb begin
      acc_neg   = acc[ACC_W-1];
      acc_abs   = acc_neg ? $unsigned(-acc) : $unsigned(acc);
      acc_shift = acc_abs >> OUT_SHIFT;
      fmt       = '0;
      if (relu_q && acc_neg)
         fmt = '0;
      else if (acc_shift > ACC_W'(MAG_MAX))
         fmt = {acc_neg, {MAG_W{1'b1}}};
      else if (acc_shift == '0)
         fmt = '0;
      else
         fmt = {acc_neg, acc_shift[MAG_W-1:0]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_ACCUM;
         ST_ACCUM: if (accept && (cnt == LAST_BEAT)) state_nxt = ST_SAT;
         ST_SAT:   state_nxt = ST_OUT;
         ST_OUT:   if (out_valid_q && out_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc         <= '0;
         cnt         <= '0;
         relu_q      <= 1'b0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  acc    <= bias_tc;
                  relu_q <= relu_en;
                  cnt    <= '0;
               end
            end
            ST_ACCUM: begin
               if (accept) begin
                  acc <= acc + beat_sum;
                  cnt <= cnt + 1'b1;
               end
            end
            ST_SAT: begin
               out_q       <= fmt;
               out_valid_q <= 1'b1;
            end
            ST_OUT: begin
               if (out_ready)
                  out_valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state != ST_IDLE);
   assign in_ready  = (state == ST_ACCUM);
   assign out_valid = out_valid_q;
   assign out       = out_q;

endmodule

// File: tb/tb_pe_stream_mac.sv
// Directed bench for pe_stream_mac: four instances cover the N_IN/LANES/OUT_SHIFT
// variants; each job is driven on the falling edge and checked half a cycle later.
module tb_pe_stream_mac;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  bias;
   logic        relu_en;
   logic        in_valid;
   logic [31:0] in_data;
   logic [31:0] w_data;
   logic        out_ready;
   logic        start_v [4];
   logic        busy_v  [4];
   logic        rdy_v   [4];
   logic        ov_v    [4];
   logic [7:0]  o_v     [4];

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   // 0: N_IN=4  1: N_IN=62  2: N_IN=6  3: N_IN=4 with OUT_SHIFT=2
   pe_stream_mac #(.DATA_W(8), .N_IN(4), .LANES(4), .ACC_W(24), .OUT_SHIFT(0)) dut_a (
      .clk(clk), .rst(rst), .start(start_v[0]), .bias(bias), .relu_en(relu_en),
      .busy(busy_v[0]), .in_valid(in_valid), .in_ready(rdy_v[0]), .in_data(in_data),
      .w_data(w_data), .out_valid(ov_v[0]), .out_ready(out_ready), .out(o_v[0]));

   pe_stream_mac #(.DATA_W(8), .N_IN(62), .LANES(4), .ACC_W(24), .OUT_SHIFT(0)) dut_b (
      .clk(clk), .rst(rst), .start(start_v[1]), .bias(bias), .relu_en(relu_en),
      .busy(busy_v[1]), .in_valid(in_valid), .in_ready(rdy_v[1]), .in_data(in_data),
      .w_data(w_data), .out_valid(ov_v[1]), .out_ready(out_ready), .out(o_v[1]));

   pe_stream_mac #(.DATA_W(8), .N_IN(6), .LANES(4), .ACC_W(24), .OUT_SHIFT(0)) dut_c (
      .clk(clk), .rst(rst), .start(start_v[2]), .bias(bias), .relu_en(relu_en),
      .busy(busy_v[2]), .in_valid(in_valid), .in_ready(rdy_v[2]), .in_data(in_data),
      .w_data(w_data), .out_valid(ov_v[2]), .out_ready(out_ready), .out(o_v[2]));

   pe_stream_mac #(.DATA_W(8), .N_IN(4), .LANES(4), .ACC_W(24), .OUT_SHIFT(2)) dut_d (
      .clk(clk), .rst(rst), .start(start_v[3]), .bias(bias), .relu_en(relu_en),
      .busy(busy_v[3]), .in_valid(in_valid), .in_ready(rdy_v[3]), .in_data(in_data),
      .w_data(w_data), .out_valid(ov_v[3]), .out_ready(out_ready), .out(o_v[3]));

   // Case 1 operands: in={+100,+93,-103,-127}, w={-5,+4,-3,+2}, lane 0 in the LSBs.
   localparam logic [31:0] C1_IN = 32'hFFE75D64;
   localparam logic [31:0] C1_W  = 32'h02830485;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic start_job(input int d, input logic [7:0] b, input logic relu);
      bias       = b;
      relu_en    = relu;
      start_v[d] = 1'b1;
      @(negedge clk);
      start_v[d] = 1'b0;
      bias       = 8'($urandom);
      chk("busy_after_start", 32'(busy_v[d]), 32'd1);
   endtask

   task automatic send_beat(input int d, input logic [31:0] ind, input logic [31:0] wd);
      in_valid = 1'b1;
      in_data  = ind;
      w_data   = wd;
      chk("in_ready", 32'(rdy_v[d]), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = $urandom;
      w_data   = $urandom;
   endtask

   // Called right after the last beat: SAT this cycle, out_valid one edge later.
   task automatic finish_job(input int d, input string tag, input logic [7:0] exp);
      chk({tag, "_sat_no_valid"}, 32'(ov_v[d]), 32'd0);
      @(negedge clk);
      chk({tag, "_valid"}, 32'(ov_v[d]), 32'd1);
      chk({tag, "_out"}, 32'(o_v[d]), 32'(exp));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_valid_drop"}, 32'(ov_v[d]), 32'd0);
      chk({tag, "_idle"}, 32'(busy_v[d]), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      bias      = '0;
      relu_en   = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      w_data    = '0;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) start_v[i] = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy_v[0]), 32'd0);
      chk("rst_in_ready", 32'(rdy_v[0]), 32'd0);
      chk("rst_out_valid", 32'(ov_v[0]), 32'd0);
      chk("rst_out", 32'(o_v[0]), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Case 1: -73 + 100 = 27
      start_job(0, 8'h64, 1'b0);
      send_beat(0, C1_IN, C1_W);
      finish_job(0, "c1", 8'h1B);

      // Case 2: 62 * 16129 + 100 saturates positive, then negative
      start_job(1, 8'h64, 1'b0);
      for (int b = 0; b < 16; b++) send_beat(1, 32'h7F7F7F7F, 32'h7F7F7F7F);
      finish_job(1, "c2_pos", 8'h7F);
      start_job(1, 8'h64, 1'b0);
      for (int b = 0; b < 16; b++) send_beat(1, 32'h7F7F7F7F, 32'hFFFFFFFF);
      finish_job(1, "c2_neg", 8'hFF);

      // Case 3: 6 real lanes of +1*+2, masked lanes carry random data
      start_job(2, 8'h00, 1'b0);
      send_beat(2, 32'h01010101, 32'h02020202);
      send_beat(2, {16'($urandom), 16'h0101}, {16'($urandom), 16'h0202});
      finish_job(2, "c3", 8'h0C);

      // Case 4: zero operands with -0 bias; shift variants incl. negative shifted to zero
      start_job(0, 8'h80, 1'b0);
      send_beat(0, 32'h00000000, 32'h55AA55AA);
      finish_job(0, "c4_negzero", 8'h00);
      start_job(3, 8'h64, 1'b0);
      send_beat(3, C1_IN, C1_W);
      finish_job(3, "c4_shift", 8'h06);
      start_job(3, 8'h83, 1'b0);
      send_beat(3, 32'h00000000, 32'h00000000);
      finish_job(3, "c4_shift_negzero", 8'h00);

      // Case 5: -73 - 100 = -173 saturates negative, or clamps with ReLU
      start_job(0, 8'hE4, 1'b0);
      send_beat(0, C1_IN, C1_W);
      finish_job(0, "c5_sat", 8'hFF);
      start_job(0, 8'hE4, 1'b1);
      send_beat(0, C1_IN, C1_W);
      finish_job(0, "c5_relu", 8'h00);

      // Case 6a: input gaps hold the accumulator
      start_job(2, 8'h00, 1'b0);
      repeat (3) @(negedge clk);
      chk("c6_gap_ready", 32'(rdy_v[2]), 32'd1);
      send_beat(2, 32'h01010101, 32'h02020202);
      repeat (2) @(negedge clk);
      chk("c6_gap2_ready", 32'(rdy_v[2]), 32'd1);
      send_beat(2, 32'h00000101, 32'h00000202);
      chk("c6_sat", 32'(ov_v[2]), 32'd0);
      @(negedge clk);

      // Case 6b: backpressure holds result; start while busy and on accept is ignored
      for (int i = 0; i < 5; i++) begin
         start_v[2] = (i == 2);
         bias       = 8'($urandom);
         @(negedge clk);
         chk("c6_hold_valid", 32'(ov_v[2]), 32'd1);
         chk("c6_hold_out", 32'(o_v[2]), 32'h0C);
      end
      start_v[2] = 1'b1;
      out_ready  = 1'b1;
      @(negedge clk);
      start_v[2] = 1'b0;
      out_ready  = 1'b0;
      chk("c6_accept_valid", 32'(ov_v[2]), 32'd0);
      chk("c6_start_ignored", 32'(busy_v[2]), 32'd0);
      @(negedge clk);
      chk("c6_still_idle", 32'(busy_v[2]), 32'd0);

      // Case 6c: reset in ACCUM clears handshake outputs without a clock edge
      start_job(0, 8'h64, 1'b0);
      rst = 1'b1;
      #1;
      chk("c6_rst_ready", 32'(rdy_v[0]), 32'd0);
      chk("c6_rst_busy", 32'(busy_v[0]), 32'd0);
      chk("c6_rst_valid", 32'(ov_v[0]), 32'd0);
      chk("c6_rst_out", 32'(o_v[0]), 32'd0);
      #1;
      rst = 1'b0;
      @(negedge clk);
      start_job(0, 8'h64, 1'b0);
      send_beat(0, C1_IN, C1_W);
      finish_job(0, "c6_after_rst", 8'h1B);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
